// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: multichannel ADC scan sequencer with framed output FIFO.
// Steps a mux address, waits a settle time, samples the ADC and queues the byte.
// Each frame ends with END_MARK, CR, LF. A frame is admitted only when it fits.
module adc_scan_ctrl #(
    parameter int unsigned CH_NUM   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DW       = 8,
    parameter int unsigned SETTLE   = 5000000,
    parameter int unsigned SWEEPS   = 1,
    parameter int unsigned FRAMES   = 50,
    parameter logic [7:0]  END_MARK = 8'hCC,
    parameter int unsigned FIFO_AW  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DW-1:0]     adc_data,
    output logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    output logic [DW-1:0]     rd_data,
    output logic              empty,
    output logic              full,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              overflow,
    output logic [3:0]        state_dbg
);

    localparam int unsigned DEPTH       = 1 << FIFO_AW;
    localparam int unsigned LVL_W       = FIFO_AW + 1;
    localparam int unsigned FRAME_BYTES = CH_NUM * SWEEPS + 3;
    localparam bit          FRAME_FITS  = (FRAME_BYTES <= DEPTH);
    localparam int unsigned ADMIT_MAX   = FRAME_FITS ? (DEPTH - FRAME_BYTES) : 0;
    localparam int unsigned SCW         = $clog2(SETTLE + 1);
    localparam int unsigned SWW         = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT     = 4'd1,
        S_SETTLE   = 4'd2,
        S_SAMPLE   = 4'd3,
        S_NEXT     = 4'd4,
        S_TRAIL_END = 4'd5,
        S_TRAIL_CR = 4'd6,
        S_TRAIL_LF = 4'd7,
        S_CHECK    = 4'd8
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [SCW-1:0]    settle_cnt;
    logic [SWW-1:0]    sweep;
    logic              stop_pend;
    logic              wr_req;
    logic [DW-1:0]     wr_byte;

    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [DW-1:0]      mem [DEPTH];

    logic              space_ok;
    logic              settle_done;
    logic              last_ch;
    logic              run_end;
    logic              wr_ok;
    logic              rd_ok;
    logic [LVL_W-1:0]  level_nx;

    // decoded per-state actions
    logic              wr_set;
    logic [DW-1:0]     wr_val;
    logic              run_start;
    logic              frame_end;
    logic              adv;

    assign space_ok    = FRAME_FITS && (fifo_level <= LVL_W'(ADMIT_MAX));
    assign settle_done = (settle_cnt == SCW'(SETTLE - 1));
    assign last_ch     = (addr == ADDR_W'(CH_NUM - 1)) && (sweep == SWW'(SWEEPS - 1));
    assign run_end     = stop_pend || stop ||
                         ((FRAMES != 0) && ((17'(frame_cnt) + 17'd1) == 17'(FRAMES)));
    assign state_dbg   = state;

    assign wr_ok    = wr_req && !full;
    assign rd_ok    = rd_en && !empty;
    assign level_nx = fifo_level + LVL_W'(wr_ok) - LVL_W'(rd_ok);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (start)       state_nx = S_WAIT;
            S_WAIT:      if (space_ok)    state_nx = S_SETTLE;
            S_SETTLE:    if (settle_done) state_nx = S_SAMPLE;
            S_SAMPLE:    state_nx = last_ch ? S_TRAIL_END : S_NEXT;
            S_NEXT:      state_nx = S_SETTLE;
            S_TRAIL_END: state_nx = S_TRAIL_CR;
            S_TRAIL_CR:  state_nx = S_TRAIL_LF;
            S_TRAIL_LF:  state_nx = S_CHECK;
            S_CHECK:     state_nx = run_end ? S_IDLE : S_WAIT;
            default:     state_nx = S_IDLE;
        endcase
    end

    // per-state action decode
    always_comb begin
        wr_set    = 1'b0;
        wr_val    = '0;
        run_start = 1'b0;
        frame_end = 1'b0;
        adv       = 1'b0;
        case (state)
            S_IDLE:      run_start = start;
            S_SAMPLE:    begin wr_set = 1'b1; wr_val = adc_data;       end
            S_NEXT:      adv = 1'b1;
            S_TRAIL_END: begin wr_set = 1'b1; wr_val = DW'(END_MARK);  end
            S_TRAIL_CR:  begin wr_set = 1'b1; wr_val = DW'(8'h0D);     end
            S_TRAIL_LF:  begin wr_set = 1'b1; wr_val = DW'(8'h0A);     end
            S_CHECK:     frame_end = 1'b1;
            default:     ;
        endcase
    end

    // scan sequencing registers: settle timer, mux address, sweep, stop latch, frame stats
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            addr       <= '0;
            sweep      <= '0;
            stop_pend  <= 1'b0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            wr_req     <= 1'b0;
            wr_byte    <= '0;
        end else begin
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + SCW'(1) : '0;
            if (run_start || frame_end) begin
                addr  <= '0;
                sweep <= '0;
            end else if (adv) begin
                if (addr == ADDR_W'(CH_NUM - 1)) begin
                    addr  <= '0;
                    sweep <= sweep + SWW'(1);
                end else begin
                    addr  <= addr + ADDR_W'(1);
                end
            end
            if (state == S_IDLE) stop_pend <= 1'b0;
            else if (stop)       stop_pend <= 1'b1;
            if (run_start)
                frame_cnt <= '0;
            else if (frame_end && (frame_cnt != 16'hFFFF))
                frame_cnt <= frame_cnt + 16'd1;
            frame_done <= frame_end;
            busy       <= (state_nx != S_IDLE);
            wr_req     <= wr_set;
            wr_byte    <= wr_val;
        end
    end

    // FIFO storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wr_byte;
    end

    // FIFO pointers, flags, registered read data and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + FIFO_AW'(1);
            if (rd_ok) begin
                rptr    <= rptr + FIFO_AW'(1);
                rd_data <= mem[rptr];
            end
            fifo_level <= level_nx;
            empty      <= (level_nx == '0);
            full       <= (level_nx == LVL_W'(DEPTH));
            if (wr_req && full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: vector table for the first frame, hand sequences for the
// corner cases, and randomized runs checked against a byte-stream queue model.
module tb_adc_scan_ctrl;

    localparam int unsigned CH = 4;
    localparam int unsigned SW = 2;

    logic        clk;
    logic        reset;
    logic        start, stop, rd_en;
    logic [7:0]  adc_data;
    logic [1:0]  addr;
    logic [7:0]  rd_data;
    logic        empty, full, busy, frame_done, overflow;
    logic [4:0]  fifo_level;
    logic [15:0] frame_cnt;
    logic [3:0]  state_dbg;

    logic        u2_start, u2_stop, u2_rd_en;
    logic [7:0]  u2_adc_data;
    logic [1:0]  u2_addr;
    logic [7:0]  u2_rd_data;
    logic        u2_empty, u2_full, u2_busy, u2_frame_done, u2_overflow;
    logic [4:0]  u2_fifo_level;
    logic [15:0] u2_frame_cnt;
    logic [3:0]  u2_state_dbg;

    logic [7:0]  adc_lut [CH];
    logic [7:0]  exp_q [$];
    logic [7:0]  last_exp;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fd_cnt = 0;

    typedef struct {
        logic       start;
        logic       rd_en;
        logic [3:0] st;
        logic [1:0] ad;
        logic [4:0] lvl;
        logic       bsy;
        logic       fd;
    } vec_t;
    vec_t tv [46];

    assign adc_data    = adc_lut[addr];
    assign u2_adc_data = adc_lut[u2_addr];

    adc_scan_ctrl #(.CH_NUM(4), .ADDR_W(2), .DW(8), .SETTLE(3), .SWEEPS(2),
                    .FRAMES(2), .END_MARK(8'hCC), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .adc_data(adc_data),
        .addr(addr), .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
        .fifo_level(fifo_level), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .overflow(overflow), .state_dbg(state_dbg)
    );

    adc_scan_ctrl #(.CH_NUM(4), .ADDR_W(2), .DW(8), .SETTLE(3), .SWEEPS(2),
                    .FRAMES(0), .END_MARK(8'hCC), .FIFO_AW(4)) dut_cont (
        .clk(clk), .reset(reset), .start(u2_start), .stop(u2_stop), .adc_data(u2_adc_data),
        .addr(u2_addr), .rd_en(u2_rd_en), .rd_data(u2_rd_data), .empty(u2_empty),
        .full(u2_full), .fifo_level(u2_fifo_level), .busy(u2_busy),
        .frame_done(u2_frame_done), .frame_cnt(u2_frame_cnt), .overflow(u2_overflow),
        .state_dbg(u2_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected stream: per frame, SW sweeps of every channel, then the trailer.
    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int s = 0; s < int'(SW); s++)
                for (int c = 0; c < int'(CH); c++) exp_q.push_back(adc_lut[c]);
            exp_q.push_back(8'hCC);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic pop_chk;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_data: got %0h with model queue empty", rd_data);
        end else begin
            last_exp = exp_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(last_exp));
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 64 && !empty; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            pop_chk();
        end
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_model_left", 32'(exp_q.size()), 32'd0);
    endtask

    // One full run with a concurrent reader; optional start pulse while busy.
    task automatic session(input int restart_at, input int rd_pct);
        int fd0;
        bit pend;
        bit done;
        fd0  = fd_cnt;
        done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            start = (c == restart_at);
            rd_en = (int'($urandom_range(99)) < rd_pct);
            pend  = rd_en && !empty;
            tick();
            if (pend) pop_chk();
            if (!busy && empty) done = 1'b1;
        end
        start = 1'b0;
        rd_en = 1'b0;
        tick();
        chk("session_done", 32'(done), 32'd1);
        chk("session_frames", 32'(frame_cnt), 32'd2);
        chk("session_fd_pulses", 32'(fd_cnt - fd0), 32'd2);
        chk("session_model_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int wait_n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; rd_en = 1'b0;
        u2_start = 1'b0; u2_stop = 1'b0; u2_rd_en = 1'b0;
        last_exp = 8'h00;
        for (int i = 0; i < int'(CH); i++) adc_lut[i] = 8'(8'h10 + i);

        // First-frame timeline from the channel-period rules
        for (int c = 0; c < 46; c++) begin
            int j, p, k, lv;
            j = (c < 2) ? 0 : (c - 2) / 5;
            p = (c < 2) ? 0 : (c - 2) % 5;
            tv[c].start = (c == 0);
            tv[c].rd_en = 1'b0;
            if (c == 0)       tv[c].st = 4'd0;
            else if (c == 1)  tv[c].st = 4'd1;
            else if (c <= 40) tv[c].st = (p < 3) ? 4'd2 : ((p == 3) ? 4'd3 : 4'd4);
            else if (c <= 44) tv[c].st = 4'(c - 36);
            else              tv[c].st = 4'd1;
            tv[c].ad = (c < 2 || c == 45) ? 2'd0 : 2'(((j > 7) ? 7 : j) % 4);
            lv = 0;
            for (k = 0; k < 8; k++) if (7 + 5 * k <= c) lv++;
            lv += (c >= 43) + (c >= 44) + (c >= 45);
            tv[c].lvl = 5'(lv);
            tv[c].bsy = (c >= 1);
            tv[c].fd  = (c == 45);
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);

        // Frame 1 with reader idle
        push_frames(2);
        for (int c = 0; c < 46; c++) begin
            start = tv[c].start;
            rd_en = tv[c].rd_en;
            chk($sformatf("tv%0d_state", c), 32'(state_dbg), 32'(tv[c].st));
            chk($sformatf("tv%0d_addr", c), 32'(addr), 32'(tv[c].ad));
            chk($sformatf("tv%0d_level", c), 32'(fifo_level), 32'(tv[c].lvl));
            chk($sformatf("tv%0d_busy", c), 32'(busy), 32'(tv[c].bsy));
            chk($sformatf("tv%0d_fd", c), 32'(frame_done), 32'(tv[c].fd));
            tick();
            start = 1'b0;
        end

        // Admission stall: 5 free words cannot take an 11-byte frame
        for (int i = 0; i < 3; i++) begin
            chk("stall_state", 32'(state_dbg), 32'd1);
            chk("stall_level", 32'(fifo_level), 32'd11);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            pop_chk();
        end
        chk("admit_level", 32'(fifo_level), 32'd5);
        chk("admit_wait_state", 32'(state_dbg), 32'd1);
        tick();
        chk("admit_settle", 32'(state_dbg), 32'd2);
        repeat (3) tick();
        chk("f2_sample_state", 32'(state_dbg), 32'd3);
        tick();
        chk("rdwr_level_before", 32'(fifo_level), 32'd5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        pop_chk();
        chk("rdwr_level_after", 32'(fifo_level), 32'd5);
        wait_n = 0;
        while (busy && wait_n < 300) begin tick(); wait_n++; end
        chk("f2_busy_drop", 32'(busy), 32'd0);
        tick();
        chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("f2_level", 32'(fifo_level), 32'd15);
        chk("f2_fd_total", 32'(fd_cnt), 32'd2);
        drain();

        // Read on empty leaves rd_data holding the last byte
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rd_data", 32'(rd_data), 32'(last_exp));
        chk("empty_rd_level", 32'(fifo_level), 32'd0);
        chk("empty_rd_empty", 32'(empty), 32'd1);

        // stop in IDLE is ignored; start while busy is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("idle_stop_state", 32'(state_dbg), 32'd0);
        for (int i = 0; i < int'(CH); i++) adc_lut[i] = 8'(8'h20 + i);
        push_frames(2);
        session(10, 100);

        // Randomized runs against the queue model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < int'(CH); i++) adc_lut[i] = 8'($urandom);
            push_frames(2);
            session(-1, int'($urandom_range(100, 25)));
        end

        // Reset mid-run, then a clean frame pair
        for (int i = 0; i < int'(CH); i++) adc_lut[i] = 8'(8'h30 + i);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_n = 0;
        while (!(state_dbg == 4'd2 && addr == 2'd2) && wait_n < 100) begin tick(); wait_n++; end
        chk("mid_reach_ch2", 32'(addr), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_state", 32'(state_dbg), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        push_frames(2);
        session(-1, 100);

        // Continuous mode: stop mid-frame completes that frame, then halts
        u2_start = 1'b1;
        tick();
        u2_start = 1'b0;
        wait_n = 0;
        while (!(u2_state_dbg == 4'd2 && u2_addr == 2'd1) && wait_n < 100) begin tick(); wait_n++; end
        chk("stop_reach_ch1", 32'(u2_addr), 32'd1);
        u2_stop = 1'b1;
        tick();
        u2_stop = 1'b0;
        wait_n = 0;
        while (u2_busy && wait_n < 300) begin tick(); wait_n++; end
        chk("stop_busy_drop", 32'(u2_busy), 32'd0);
        chk("stop_frame_cnt", 32'(u2_frame_cnt), 32'd1);
        chk("stop_level", 32'(u2_fifo_level), 32'd11);
        chk("stop_state", 32'(u2_state_dbg), 32'd0);

        // Forced writes past full set the sticky overflow flag
        force dut.wr_req = 1'b1;
        repeat (18) tick();
        release dut.wr_req;
        tick();
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        chk("ovf_after_rd_level", 32'(fifo_level), 32'd15);
        chk("ovf_after_rd_full", 32'(full), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf_reset_clear", 32'(overflow), 32'd0);
        chk("ovf_reset_level", 32'(fifo_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
